// File: rtl/reg_bank_pkg.sv
// Shared definitions for the general-purpose register bank: lane helpers and
// the byte-lane merge used by both the write path and the read-port bypass.
package reg_bank_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int MAX_WIDTH = 256;
  localparam int MAX_LANES = MAX_WIDTH / 8;

  typedef logic [MAX_WIDTH-1:0] word_t;
  typedef logic [MAX_LANES-1:0] lanes_t;

  function automatic int lane_count(input int width);
    return width / 8;
  endfunction

  // Lanes with a set strobe take the new word, all others keep the old one.
  // Operands are zero-extended to MAX_WIDTH by the caller and truncated back.
  function automatic word_t lane_merge(input word_t old_w, input word_t new_w, input lanes_t be);
    word_t res;
    res = old_w;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_bank_rport.sv
// One combinational read port: address decode, range check, R0 zeroing and
// optional forwarding of the write being committed this cycle.
module reg_bank_rport
  import reg_bank_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = 16,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1,
  parameter int ADDR_W  = 4
) (
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [DEPTH*WIDTH-1:0]  regs_flat,
  input  logic                    wr_fwd,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [WIDTH/8-1:0]      wr_be,
  output logic [WIDTH-1:0]        rd_data
);

  logic [WIDTH-1:0] stored;
  word_t            merged;

  // Out-of-range addresses match no entry and fall through to zero.
  always_comb begin
    stored = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) stored = regs_flat[i*WIDTH +: WIDTH];
    end
    if (R0_ZERO && rd_addr == '0) stored = '0;

    merged = lane_merge(word_t'(stored), word_t'(wr_data), lanes_t'(wr_be));

    if (BYPASS && wr_fwd && rd_addr == wr_addr) rd_data = merged[WIDTH-1:0];
    else rd_data = stored;
  end

endmodule

// File: rtl/reg_bank.sv
// General-purpose register file: one byte-strobed write port, two
// combinational read ports, synchronous bulk clear and invalid-write flag.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = 16,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LANES  = lane_count(WIDTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              sclr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [LANES-1:0]  wr_be,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              wr_err
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]       regs [DEPTH];
  logic [DEPTH*WIDTH-1:0] regs_flat;
  logic                   addr_ok;
  logic                   r0_hit;
  logic                   wr_hit;
  logic                   wr_bad;
  logic [WIDTH-1:0]       wr_old;
  logic [WIDTH-1:0]       wr_merged;
  word_t                  merged_full;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
  end

  // wr_hit also drives forwarding, so it excludes sclr and a hardwired R0.
  always_comb begin
    addr_ok = {1'b0, wr_addr} < DEPTH_W;
    r0_hit  = R0_ZERO && wr_addr == '0;
    wr_hit  = en && !sclr && addr_ok && !r0_hit;
    wr_bad  = en && (|wr_be) && !addr_ok;

    wr_old = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == ADDR_W'(i)) wr_old = regs[i];
    end
    merged_full = lane_merge(word_t'(wr_old), word_t'(wr_data), lanes_t'(wr_be));
    wr_merged   = merged_full[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_err <= 1'b0;
    end else if (sclr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_bad;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit && wr_addr == ADDR_W'(i)) regs[i] <= wr_merged;
      end
    end
  end

  reg_bank_rport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO), .BYPASS(BYPASS), .ADDR_W(ADDR_W)
  ) u_rport_a (
    .rd_addr  (rd_addr_a),
    .regs_flat(regs_flat),
    .wr_fwd   (wr_hit),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_data  (rd_data_a)
  );

  reg_bank_rport #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO), .BYPASS(BYPASS), .ADDR_W(ADDR_W)
  ) u_rport_b (
    .rd_addr  (rd_addr_b),
    .regs_flat(regs_flat),
    .wr_fwd   (wr_hit),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_data  (rd_data_b)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (WIDTH=32, DEPTH=12, R0 zeroed, bypass on)
// against a word-array model of the register file.
module tb_reg_bank;

  localparam int DEPTH = 12;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic        sclr;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        wr_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic        model_err;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(32), .DEPTH(DEPTH), .R0_ZERO(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .clr(clr), .en(en), .sclr(sclr),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_err(wr_err)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_w & mask) | (old_w & ~mask);
  endfunction

  // Value a read port should show right now, given the inputs being applied.
  function automatic logic [31:0] exp_read(input logic [3:0] a);
    if (a >= DEPTH || a == 0) return 32'h0;
    if (en && !sclr && a == wr_addr) return merge(model[a], wr_data, wr_be);
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    model_err = 1'b0;
  endtask

  task automatic drive(input logic e, input logic s, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    en = e; sclr = s; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_addr_a = ra; rd_addr_b = rb;
    #1;
  endtask

  // Advance one rising edge and apply the same edge to the model.
  task automatic clock_edge();
    @(posedge clk);
    if (sclr) begin
      model_clear();
    end else begin
      model_err = en && (wr_be != 4'h0) && (wr_addr >= DEPTH);
      if (en && wr_addr < DEPTH && wr_addr != 0) model[wr_addr] = merge(model[wr_addr], wr_data, wr_be);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 4'(a), 4'(15 - a));
      checks++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_read addr=%0d got a=%h b=%h want 0", a, rd_data_a, rd_data_b);
      end
    end
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wr_err got %b want 0", wr_err);
    end
  endtask

  task automatic test_async_clear();
    drive(1'b1, 1'b0, 4'd3, 32'h0000_005C, 4'hF, 4'd3, 4'd3);
    clock_edge();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 4'd3, 4'd3);
    checks++;
    if (rd_data_a !== 32'h0000_005C) begin
      errors++;
      $display("[TB] FAIL load_r3 got %h want 0000005c", rd_data_a);
    end
    #1 clr = 1'b0;
    #1;
    model_clear();
    checks++;
    if (rd_data_a !== 32'h0 || wr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_clear got r3=%h err=%b want 0 0", rd_data_a, wr_err);
    end
    clr = 1'b1;
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 1'b0, 4'd5, 32'hAAAA_AAAA, 4'hF, 4'd5, 4'd0);
    clock_edge();
    drive(1'b1, 1'b0, 4'd5, 32'hFB02_1234, 4'b0101, 4'd5, 4'd5);
    checks++;
    if (rd_data_a !== 32'hAA02_AA34 || rd_data_b !== 32'hAA02_AA34) begin
      errors++;
      $display("[TB] FAIL bypass_lanes got a=%h b=%h want aa02aa34", rd_data_a, rd_data_b);
    end
    clock_edge();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 4'd5, 4'd5);
    checks++;
    if (rd_data_a !== 32'hAA02_AA34) begin
      errors++;
      $display("[TB] FAIL write_lanes got %h want aa02aa34", rd_data_a);
    end
  endtask

  task automatic test_r0();
    drive(1'b1, 1'b0, 4'd0, 32'hFFFF_FFFF, 4'hF, 4'd0, 4'd0);
    checks++;
    if (rd_data_b !== 32'h0) begin
      errors++;
      $display("[TB] FAIL r0_bypass got %h want 0", rd_data_b);
    end
    clock_edge();
    checks++;
    if (rd_data_b !== 32'h0 || wr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r0_write got %h err=%b want 0 0", rd_data_b, wr_err);
    end
  endtask

  task automatic test_invalid();
    drive(1'b1, 1'b0, 4'd13, 32'h1357_9BDF, 4'hF, 4'd13, 4'd5);
    checks++;
    if (rd_data_a !== 32'h0) begin
      errors++;
      $display("[TB] FAIL oor_read got %h want 0", rd_data_a);
    end
    clock_edge();
    checks++;
    if (wr_err !== 1'b1 || rd_data_b !== model[5]) begin
      errors++;
      $display("[TB] FAIL invalid_set got err=%b r5=%h want 1 %h", wr_err, rd_data_b, model[5]);
    end
    drive(1'b0, 1'b0, 4'd13, 32'h1357_9BDF, 4'hF, 4'd13, 4'd13);
    clock_edge();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL invalid_one_cycle got err=%b want 0", wr_err);
    end
  endtask

  task automatic test_enable();
    drive(1'b0, 1'b0, 4'd2, 32'h0000_0001, 4'hF, 4'd2, 4'd2);
    checks++;
    if (rd_data_a !== model[2]) begin
      errors++;
      $display("[TB] FAIL en0_no_bypass got %h want %h", rd_data_a, model[2]);
    end
    clock_edge();
    checks++;
    if (rd_data_a !== model[2]) begin
      errors++;
      $display("[TB] FAIL en0_hold got %h want %h", rd_data_a, model[2]);
    end
    drive(1'b1, 1'b0, 4'd2, 32'h0000_0001, 4'hF, 4'd3, 4'd2);
    clock_edge();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 4'd2, 4'd2);
    checks++;
    if (rd_data_b !== 32'h0000_0001) begin
      errors++;
      $display("[TB] FAIL en1_write got %h want 00000001", rd_data_b);
    end
  endtask

  task automatic test_sclr();
    drive(1'b1, 1'b0, 4'd7, 32'hDEAD_BEEF, 4'hF, 4'd7, 4'd7);
    clock_edge();
    drive(1'b1, 1'b0, 4'd14, 32'h0, 4'h1, 4'd7, 4'd7);
    clock_edge();
    drive(1'b1, 1'b1, 4'd7, 32'h0000_0005, 4'hF, 4'd7, 4'd7);
    checks++;
    if (rd_data_a !== 32'hDEAD_BEEF || wr_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sclr_no_bypass got %h err=%b want deadbeef 1", rd_data_a, wr_err);
    end
    clock_edge();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sclr_err got %b want 0", wr_err);
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 4'(a), 4'(a));
      checks++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
        errors++;
        $display("[TB] FAIL sclr_zero addr=%0d got a=%h b=%h want 0", a, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] ra;
    logic [3:0] rb;
    for (int n = 0; n < 400; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
            $urandom, 4'($urandom), ra, rb);
      checks++;
      if (rd_data_a !== exp_read(rd_addr_a) || rd_data_b !== exp_read(rd_addr_b)) begin
        errors++;
        $display("[TB] FAIL rand_read n=%0d a[%0d]=%h want %h b[%0d]=%h want %h", n, rd_addr_a,
                 rd_data_a, exp_read(rd_addr_a), rd_addr_b, rd_data_b, exp_read(rd_addr_b));
      end
      clock_edge();
      checks++;
      if (wr_err !== model_err) begin
        errors++;
        $display("[TB] FAIL rand_wr_err n=%0d got %b want %b", n, wr_err, model_err);
      end
    end
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; sclr = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    model_clear();
    repeat (2) @(negedge clk);
    clr = 1'b1;
    test_reset();
    test_async_clear();
    test_byte_lanes();
    test_r0();
    test_invalid();
    test_enable();
    test_sclr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
